sha256_msg_padder: RTL

//   Byte-stream front end of the SHA-256 core. Packs incoming message bytes

---
 rtl/sha256_pkg.sv | 19 +
 rtl/sha256_msg_padder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: block geometry, pad byte and padder state encoding.
// Used by the message padder, message schedule and round engine.
package sha256_pkg;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_OFFSET  = 56;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_PAD  = 2'd1;
  localparam logic [1:0] ST_LEN  = 2'd2;
  localparam logic [1:0] ST_EMIT = 2'd3;

  // Byte k (0 = most significant) of the 64-bit big-endian length field.
  function automatic logic [7:0] len_byte(input logic [63:0] len, input logic [2:0] k);
    return len[8*(7-k) +: 8];
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Packs a byte stream into padded 512-bit SHA-256 blocks and hands them
// downstream over valid/ready; block_last flags the final block of a message.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] block,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_last
);

  logic [1:0]       state_q, state_d;
  logic [6:0]       idx_q, idx_d;
  logic [LEN_W-1:0] bitlen_q, bitlen_d;
  logic             msg_done_q, msg_done_d;
  logic             pad_done_q, pad_done_d;
  logic             last_q, last_d;
  logic [7:0]       buf_q [BLOCK_BYTES];
  logic [7:0]       buf_d [BLOCK_BYTES];
  logic [63:0]      len64;
  logic [6:0]       idx_inc;

  assign len64   = 64'(bitlen_q);
  assign idx_inc = idx_q + 7'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bitlen_d   = bitlen_q;
    msg_done_d = msg_done_q;
    pad_done_d = pad_done_q;
    last_d     = last_q;
    buf_d      = buf_q;
    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          buf_d[idx_q[5:0]] = in_data;
          idx_d             = idx_inc;
          bitlen_d          = bitlen_q + LEN_W'(8);
          msg_done_d        = msg_done_q | in_last;
          if (idx_inc == 7'(BLOCK_BYTES)) begin
            state_d = ST_EMIT;
            last_d  = 1'b0;
          end else if (in_last) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        buf_d[idx_q[5:0]] = PAD_BYTE;
        idx_d             = idx_inc;
        pad_done_d        = 1'b1;
        state_d           = ST_EMIT;
        // Length fits after the pad byte only if the pad landed at or before byte 55.
        if (idx_inc <= 7'(LEN_OFFSET)) begin
          for (int k = 0; k < 8; k++) begin
            buf_d[6'(LEN_OFFSET + k)] = len_byte(len64, 3'(k));
          end
          last_d = 1'b1;
        end else begin
          last_d = 1'b0;
        end
      end
      ST_LEN: begin
        for (int i = 0; i < BLOCK_BYTES; i++) begin
          buf_d[6'(i)] = 8'h00;
        end
        for (int k = 0; k < 8; k++) begin
          buf_d[6'(LEN_OFFSET + k)] = len_byte(len64, 3'(k));
        end
        last_d  = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (block_ready) begin
          // Clearing here is what provides the zero fill for the next block.
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            buf_d[6'(i)] = 8'h00;
          end
          idx_d  = 7'd0;
          last_d = 1'b0;
          if (!msg_done_q) begin
            state_d = ST_FILL;
          end else if (!pad_done_q) begin
            state_d = ST_PAD;
          end else if (!last_q) begin
            state_d = ST_LEN;
          end else begin
            state_d    = ST_FILL;
            bitlen_d   = '0;
            msg_done_d = 1'b0;
            pad_done_d = 1'b0;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      idx_q      <= '0;
      bitlen_q   <= '0;
      msg_done_q <= 1'b0;
      pad_done_q <= 1'b0;
      last_q     <= 1'b0;
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bitlen_q   <= bitlen_d;
      msg_done_q <= msg_done_d;
      pad_done_q <= pad_done_d;
      last_q     <= last_d;
      buf_q      <= buf_d;
    end
  end

  // Outputs are forced quiet during the reset cycle itself.
  assign in_ready    = !rst && (state_q == ST_FILL);
  assign block_valid = !rst && (state_q == ST_EMIT);
  assign block_last  = !rst && last_q;

  for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_block
    assign block[511-8*g -: 8] = rst ? 8'h00 : buf_q[g];
  end

endmodule
